// File: rtl/somador_sequencial.sv
// somador_sequencial: multi-cycle adder/subtractor processing CHUNK bits per clock.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, sub        request (taken when not busy), 0 = add / 1 = subtract
//   A, B, Cin         operands and carry/borrow-in, captured on accept
//   S, Cout, Ovf      registered result, carry out (1 = no borrow on subtract), signed overflow
//   busy, done        operation in progress, one-cycle result-update pulse
module somador_sequencial #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf,
   output logic             busy,
   output logic             done
);

   localparam int unsigned NSTEPS = WIDTH / CHUNK;
   localparam int unsigned CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
   localparam int unsigned CW1    = CHUNK + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic             accept;
   logic             step_en;
   logic             last;
   logic             busy_nxt;
   logic             done_nxt;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_nxt;
   logic             carry_q;
   logic [CW-1:0]    step_q;

   logic [CHUNK-1:0] a_c;
   logic [CHUNK-1:0] b_c;
   logic [CW1-1:0]   sum_c;
   logic             msb_cin;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_nxt = state_q;
      accept    = 1'b0;
      step_en   = 1'b0;
      last      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step_en = 1'b1;
            if (step_q == CW'(NSTEPS - 1)) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            // A start in the done cycle is taken immediately for back-to-back throughput
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);
   end

   // Chunk adder: operands are shifted right each step, so the live chunk is always the LSBs
   always_comb begin
      a_c     = a_q[CHUNK-1:0];
      b_c     = b_q[CHUNK-1:0];
      sum_c   = CW1'(a_c) + CW1'(b_c) + CW1'(carry_q);
      // Carry into the chunk MSB recovered from the MSB sum bit
      msb_cin = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum_c[CHUNK-1];
      // Result fills from the top so that after NSTEPS steps chunk 0 sits at the LSB
      acc_nxt = WIDTH'({sum_c[CHUNK-1:0], acc_q} >> CHUNK);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         step_q  <= '0;
         S       <= '0;
         Cout    <= 1'b0;
         Ovf     <= 1'b0;
      end else if (accept) begin
         a_q     <= A;
         b_q     <= sub ? ~B : B;
         carry_q <= Cin ^ sub;
         step_q  <= '0;
      end else if (step_en) begin
         a_q     <= a_q >> CHUNK;
         b_q     <= b_q >> CHUNK;
         carry_q <= sum_c[CHUNK];
         acc_q   <= acc_nxt;
         step_q  <= step_q + CW'(1);
         if (last) begin
            S    <= acc_nxt;
            Cout <= sum_c[CHUNK];
            Ovf  <= msb_cin ^ sum_c[CHUNK];
         end
      end
   end

endmodule
